// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared fetch-PC constants and redirect buffer types
package pc_gen_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  typedef enum logic {ST_EMPTY = 1'b0, ST_HELD = 1'b1} buf_state_e;
  typedef enum logic {KIND_BR = 1'b0, KIND_EXC = 1'b1} redir_kind_e;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry buffer for redirects arriving while fetch is stalled
import pc_gen_pkg::*;
module pc_redirect_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br,
  input  logic [31:0] br_target,
  input  logic        exc,
  input  logic [31:0] exc_target,
  output logic        pending,
  output logic [31:0] target
);
  buf_state_e  state;
  redir_kind_e kind;
  logic        load;
  // an exception always claims the slot; a branch never displaces a buffered exception
  assign load = stall && (exc || (br && !(state == ST_HELD && kind == KIND_EXC)));
  assign pending = state == ST_HELD;
  // capture on stall, release the entry on the first unstalled cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state  <= ST_EMPTY;
      kind   <= KIND_BR;
      target <= '0;
    end else if (load) begin
      state  <= ST_HELD;
      kind   <= exc ? KIND_EXC : KIND_BR;
      target <= exc ? exc_target : br_target;
    end else if (!stall) state <= ST_EMPTY;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with redirect priority mux; PC_ALIGN_CHECK_EN enables the misalignment flag
import pc_gen_pkg::*;
module pc_gen #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_Stall,
  input  logic        EXE_BranchTaken,
  input  logic [31:0] EXE_BranchTarget,
  input  logic        EXC_Redirect,
  input  logic [31:0] EXC_Target,
  output logic [31:0] IF_PC,
  output logic        IF_PCValid,
  output logic        Redirect_Pending,
  output logic        IF_AddrErr
);
  logic [31:0] held_target;
  logic [31:0] next_pc;
  pc_redirect_buf u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .stall     (IF_Stall),
    .br        (EXE_BranchTaken),
    .br_target (EXE_BranchTarget),
    .exc       (EXC_Redirect),
    .exc_target(EXC_Target),
    .pending   (Redirect_Pending),
    .target    (held_target)
  );
  assign next_pc = IF_Stall         ? IF_PC :
                   EXC_Redirect     ? EXC_Target :
                   Redirect_Pending ? held_target :
                   EXE_BranchTaken  ? EXE_BranchTarget : IF_PC + 32'd4;
  // PC register and fetch-valid flag
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      IF_PC      <= RESET_PC;
      IF_PCValid <= 1'b0;
    end else begin
      IF_PC      <= next_pc;
      IF_PCValid <= 1'b1;
    end
`ifdef PC_ALIGN_CHECK_EN
  // misalignment flag registered alongside the PC it describes
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) IF_AddrErr <= 1'b0;
    else IF_AddrErr <= next_pc[1:0] != 2'b00;
`else
  assign IF_AddrErr = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized bench for pc_gen against a behavioural fetch-PC model
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        IF_Stall = 1'b0;
  logic        EXE_BranchTaken = 1'b0;
  logic [31:0] EXE_BranchTarget = '0;
  logic        EXC_Redirect = 1'b0;
  logic [31:0] EXC_Target = '0;
  logic [31:0] IF_PC;
  logic        IF_PCValid;
  logic        Redirect_Pending;
  logic        IF_AddrErr;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_pend_exc;
  pc_gen dut (
    .clk             (clk),
    .resetn          (resetn),
    .IF_Stall        (IF_Stall),
    .EXE_BranchTaken (EXE_BranchTaken),
    .EXE_BranchTarget(EXE_BranchTarget),
    .EXC_Redirect    (EXC_Redirect),
    .EXC_Target      (EXC_Target),
    .IF_PC           (IF_PC),
    .IF_PCValid      (IF_PCValid),
    .Redirect_Pending(Redirect_Pending),
    .IF_AddrErr      (IF_AddrErr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    logic exp_err;
`ifdef PC_ALIGN_CHECK_EN
    exp_err = m_pc[1:0] != 2'b00;
`else
    exp_err = 1'b0;
`endif
    check("pc", IF_PC, m_pc);
    check("valid", {31'd0, IF_PCValid}, {31'd0, m_valid});
    check("pending", {31'd0, Redirect_Pending}, {31'd0, m_pend});
    check("addr_err", {31'd0, IF_AddrErr}, {31'd0, exp_err});
  endtask
  task automatic model_reset();
    m_pc = 32'hBFC0_0000;
    m_valid = 1'b0;
    m_pend = 1'b0;
    m_tgt = '0;
    m_pend_exc = 1'b0;
  endtask
  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic e, input logic [31:0] et);
    IF_Stall = s;
    EXE_BranchTaken = b;
    EXE_BranchTarget = bt;
    EXC_Redirect = e;
    EXC_Target = et;
    @(posedge clk);
    m_valid = 1'b1;
    if (!s) begin
      m_pc = e ? et : m_pend ? m_tgt : b ? bt : m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (e) begin
      m_pend = 1'b1;
      m_tgt = et;
      m_pend_exc = 1'b1;
    end else if (b && !(m_pend && m_pend_exc)) begin
      m_pend = 1'b1;
      m_tgt = bt;
      m_pend_exc = 1'b0;
    end
    #1;
    check_all();
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;
  endtask
  initial begin
    logic [31:0] bt, et;
    logic s, b, e;
    @(posedge clk);
    #1;
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 1, 32'h8000_0100, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h8000_0200, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'hBFC0_0380);
    step(1, 1, 32'h8000_0300, 0, 0);
    step(0, 1, 32'h8000_0400, 0, 0);
    step(0, 1, 32'h8000_0500, 1, 32'hBFC0_0180);
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h8000_0102, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h8000_0600, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      s = $urandom_range(0, 1) == 1;
      b = $urandom_range(0, 3) == 0;
      e = $urandom_range(0, 7) == 0;
      bt = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFFC : $urandom & 32'hFFFF_FFFC;
      et = $urandom_range(0, 7) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
      step(s, b, bt, e, et);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator for the fetch stage. Holds the fetch PC and advances it by 4 each accepted cycle. Redirects it on a taken branch/jump resolved in EXE (the EXE flush/taken signal and its target) or on an exception redirect from MEM. Buffers any redirect that arrives while fetch is stalled, so a flush resolved under an I-cache miss is never lost.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address loaded on reset.

Ports (clock and reset asynchronous active-low, single clock domain):
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- IF_Stall  in  1  fetch cannot accept a new PC this cycle; PC must hold.
- EXE_BranchTaken  in  1  branch/jump resolved taken in EXE (same signal that flushes ID).
- EXE_BranchTarget  in  32  redirect target for EXE_BranchTaken.
- EXC_Redirect  in  1  exception/ERET redirect from MEM.
- EXC_Target  in  32  redirect target for EXC_Redirect.
- IF_PC  out  32  current fetch address.
- IF_PCValid  out  1  IF_PC is a real fetch request.
- Redirect_Pending  out  1  a redirect is buffered, waiting for fetch to unstall.
- IF_AddrErr  out  1  IF_PC misaligned (see Configuration).

## Operation
- Next-PC priority per cycle: EXC_Redirect > buffered redirect > EXE_BranchTaken > IF_PC+4.
- IF_PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Buffer FSM, two states:
  - EMPTY: no redirect buffered.
  - HELD: one redirect buffered, with a stored target and a stored kind (BR/EXC).
- EMPTY, IF_Stall=0: PC takes the highest-priority request. The FSM stays EMPTY.
- EMPTY, IF_Stall=1, any redirect asserted: latch the winning target and kind, then go to HELD. PC holds.
- HELD, IF_Stall=1:
  - A new EXC_Redirect overwrites the buffered entry, whatever its kind.
  - A new EXE_BranchTaken overwrites a BR entry only. It never overwrites an EXC entry.
  - PC holds.
- HELD, IF_Stall=0:
  - If EXC_Redirect is asserted, PC takes EXC_Target.
  - Otherwise PC takes the buffered target.
  - In both cases go to EMPTY. A simultaneous EXE_BranchTaken is dropped.
- Redirect_Pending = (state==HELD).
- Reset mid-stall or with an entry in HELD discards the buffer. This is the only way to cancel an entry.
- IF_PCValid is 0 in reset. It goes to 1 on the first rising edge after resetn deasserts and stays 1.

## Timing
- Reset values: IF_PC=RESET_PC, IF_PCValid=0, Redirect_Pending=0, IF_AddrErr=0, state EMPTY.
- Unstalled redirect: request in cycle N -> IF_PC=target in cycle N+1 (one-cycle latency).
- Stalled redirect: request in cycle N with IF_Stall=1 -> Redirect_Pending=1 from N+1. Then IF_PC=target on the cycle after the first cycle with IF_Stall=0.
- Sequential advance: IF_Stall=0 in cycle N -> IF_PC+4 in N+1. IF_Stall=1 -> IF_PC unchanged.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - IF_AddrErr is registered alongside IF_PC and equals (next IF_PC[1:0] != 0).
  - A misaligned target is still loaded unchanged, so the exception unit sees the faulting address.
- PC_ALIGN_CHECK_EN undefined:
  - IF_AddrErr is tied to 0.
  - No alignment logic is generated.

## Structure
- Shared CPU package:
  - RESET_PC default constant.
  - Enum for the FSM states (EMPTY/HELD).
  - Enum for the redirect kind (BR/EXC).
- One sub-module, pc_redirect_buf. It holds the FSM, the stored target and the stored kind, and implements the overwrite rules. pc_gen keeps the PC register and the next-PC mux.

## Test plan
- Reset release, IF_Stall=0 for 3 cycles -> IF_PC = BFC00000, BFC00004, BFC00008. IF_PCValid is 0 during reset and 1 from the first edge after release.
- EXE_BranchTaken with target 8000_0100 in cycle N, IF_Stall=0 -> IF_PC=8000_0100 in N+1, then 8000_0104.
- IF_Stall=1 for 4 cycles:
  - Branch to 8000_0200 in the 1st stall cycle -> Redirect_Pending=1.
  - IF_PC frozen throughout.
  - IF_Stall drops -> IF_PC=8000_0200 next cycle, Redirect_Pending=0.
- During a stall: EXC to BFC00380 buffered first, then a branch to 8000_0300 -> after unstall IF_PC=BFC00380. The branch is dropped.
- EXC_Redirect and EXE_BranchTaken in the same unstalled cycle -> EXC_Target wins. Also: IF_PC=FFFF_FFFC unstalled -> 0000_0000 next cycle.
- With PC_ALIGN_CHECK_EN: branch to 8000_0102 -> IF_PC=8000_0102 and IF_AddrErr=1 in the same cycle. Without the macro, IF_AddrErr stays 0.
